// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int          CNT_W_DEF = 32;
  localparam int unsigned DIV_DEF   = 1;

  // Channel-index width: clog2, but never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, toggle flop, rise strobe and
// shadowed divide ratio that is only applied on a whole-period boundary.
module clk_div_channel
  import clkdiv_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DIV_DEF
) (
  input  logic             Mclk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic             sync_clr,
  output logic             clk_out,
  output logic             strobe,
  output logic             load_pending
);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] shd;
  logic [CNT_W-1:0] cnt;
  logic             hold;
  logic             terminal;
  logic             apply_pt;

  // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
  always_comb begin
    hold     = sync_clr || !en || (div == '0);
    terminal = !hold && (cnt == div - CNT_W'(1));
    apply_pt = hold || (terminal && clk_out);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Mclk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      strobe  <= 1'b0;
    end else if (hold) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      strobe  <= 1'b0;
    end else if (terminal) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
      strobe  <= ~clk_out;
    end else begin
      cnt     <= cnt + CNT_W'(1);
      strobe  <= 1'b0;
    end
  end

  // A load landing on an apply point bypasses the shadow entirely.
  always_ff @(posedge Mclk or posedge rst) begin
    if (rst) begin
      // NOTE: the shadow is a plain register, not a memory, so resetting it is free and keeps it deterministic.
      div          <= CNT_W'(DEFAULT_DIV);
      shd          <= '0;
      load_pending <= 1'b0;
    end else if (load && apply_pt) begin
      div          <= load_div;
      load_pending <= 1'b0;
    end else if (load) begin
      shd          <= load_div;
      load_pending <= 1'b1;
    end else if (load_pending && apply_pt) begin
      div          <= shd;
      load_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent 50%-duty clock dividers sharing one load port and a
// global phase realign.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter  int          NUM_CH      = 4,
  parameter  int          CNT_W       = CNT_W_DEF,
  parameter  int unsigned DEFAULT_DIV = DIV_DEF,
  localparam int          CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              Mclk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              load_valid,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_div,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] strobe,
  output logic [NUM_CH-1:0] load_pending
);

  // Out-of-range load_ch values match no channel and are dropped here.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .Mclk         (Mclk),
      .rst          (rst),
      .en           (ch_en[i]),
      .load         (load_valid && (load_ch == CH_W'(i))),
      .load_div     (load_div),
      .sync_clr     (sync_clr),
      .clk_out      (clk_out[i]),
      .strobe       (strobe[i]),
      .load_pending (load_pending[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed + randomized bench for multi_clock_divider against a phase-position model.
module tb_multi_clock_divider;
  import clkdiv_pkg::*;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 32;
  localparam int CH_W   = ch_idx_w(NUM_CH);

  logic              Mclk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              load_valid;
  logic [CH_W-1:0]   load_ch;
  logic [CNT_W-1:0]  load_div;
  logic              sync_clr;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] strobe;
  logic [NUM_CH-1:0] load_pending;

  int vectors     = 0;
  int miscompares = 0;

  // Model: position within the current 2H-cycle period; high for pos >= H.
  longint            m_div [NUM_CH];
  longint            m_shd [NUM_CH];
  longint            m_pos [NUM_CH];
  bit                m_pend[NUM_CH];
  logic [NUM_CH-1:0] exp_clk, exp_stb, exp_pend;

  always #5 Mclk = ~Mclk;

  multi_clock_divider #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (1)
  ) dut (
    .Mclk         (Mclk),
    .rst          (rst),
    .ch_en        (ch_en),
    .load_valid   (load_valid),
    .load_ch      (load_ch),
    .load_div     (load_div),
    .sync_clr     (sync_clr),
    .clk_out      (clk_out),
    .strobe       (strobe),
    .load_pending (load_pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c]  = 1;
      m_shd[c]  = 0;
      m_pos[c]  = 0;
      m_pend[c] = 1'b0;
    end
    exp_clk  = '0;
    exp_stb  = '0;
    exp_pend = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      bit     sel, hold, wrap, apply;
      longint half;
      half  = m_div[c];
      sel   = load_valid && (int'(load_ch) == c);
      hold  = sync_clr || !ch_en[c] || (half == 0);
      wrap  = !hold && (m_pos[c] == 2 * half - 1);
      apply = hold || wrap;
      m_pos[c]   = apply ? 0 : m_pos[c] + 1;
      exp_clk[c] = !hold && (m_pos[c] >= half);
      exp_stb[c] = !hold && (m_pos[c] == half);
      if (sel && apply) begin
        m_div[c]  = load_div;
        m_pend[c] = 1'b0;
      end else if (sel) begin
        m_shd[c]  = load_div;
        m_pend[c] = 1'b1;
      end else if (apply && m_pend[c]) begin
        m_div[c]  = m_shd[c];
        m_pend[c] = 1'b0;
      end
      exp_pend[c] = m_pend[c];
    end
  endtask

  task automatic step();
    @(posedge Mclk);
    model_edge();
    #1;
    check("clk_out", clk_out, exp_clk);
    check("strobe", strobe, exp_stb);
    check("load_pending", load_pending, exp_pend);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_step(input int ch, input int div);
    load_valid = 1'b1;
    load_ch    = CH_W'(ch);
    load_div   = CNT_W'(div);
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ch_en = '0; load_valid = 1'b0; load_ch = '0; load_div = '0; sync_clr = 1'b0;
    model_reset();
    #1;
    check("reset_clk", clk_out, 0);
    check("reset_strobe", strobe, 0);
    check("reset_pending", load_pending, 0);
    @(negedge Mclk) rst = 1'b0;

    // ch0 H=3: rise after edge 3, fall after edge 6, strobe on 3, 9.
    load_step(0, 3);
    ch_en = 5'b00001;
    steps(2);
    check("h3_low_e2", clk_out[0], 0);
    step();
    check("h3_rise_e3", {clk_out[0], strobe[0]}, 2'b11);
    steps(3);
    check("h3_fall_e6", clk_out[0], 0);
    steps(3);
    check("h3_strobe_e9", strobe[0], 1);

    // Mid-high reload to 5: finishes the H=3 period, then 10-cycle period.
    load_step(0, 5);
    check("pend_set", load_pending[0], 1);
    steps(2);
    check("pend_applied", {clk_out[0], load_pending[0]}, 2'b00);
    steps(5);
    check("h5_rise", {clk_out[0], strobe[0]}, 2'b11);
    steps(5);
    check("h5_fall", clk_out[0], 0);

    // Loads of 4 then 7 overwrite; out-of-range load_ch is ignored.
    load_step(0, 4);
    load_step(0, 7);
    load_step(5, 2);
    check("pend_two_loads", load_pending, 5'b00001);
    steps(7);
    check("h7_applied", load_pending[0], 0);
    steps(6);
    check("h7_low_6", clk_out[0], 0);
    step();
    check("h7_rise_7", {clk_out[0], strobe[0]}, 2'b11);

    // Channels at 1, 2, 4 realigned by sync_clr.
    load_step(1, 1);
    load_step(2, 2);
    load_step(3, 4);
    ch_en = 5'b01111;
    steps(7);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("sync_all_low", clk_out, 0);
    step();
    check("sync_k1", {clk_out[3:1], strobe[3:1]}, 6'b001_001);
    step();
    check("sync_k2", {clk_out[3:1], strobe[3:1]}, 6'b010_010);
    step();
    check("sync_k3", {clk_out[3:1], strobe[3:1]}, 6'b011_001);
    step();
    check("sync_k4", {clk_out[3:1], strobe[3:1]}, 6'b100_100);

    // div=0 holds ch2; reloading 2 applies at once.
    ch_en[2] = 1'b0;
    load_step(2, 0);
    ch_en[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("div0_hold", {clk_out[2], strobe[2]}, 2'b00);
    end
    load_step(2, 2);
    steps(2);
    check("div0_reload", {clk_out[2], strobe[2]}, 2'b11);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) ch_en = NUM_CH'($urandom);
      load_valid = ($urandom_range(0, 5) == 0);
      load_ch    = CH_W'($urandom_range(0, 7));
      load_div   = CNT_W'($urandom_range(0, 6));
      sync_clr   = ($urandom_range(0, 49) == 0);
      step();
    end
    load_valid = 1'b0;
    sync_clr   = 1'b0;

    // Async reset in the middle of a high phase.
    ch_en = '0;
    load_step(0, 3);
    ch_en = 5'b11111;
    steps(3);
    check("pre_rst_high", clk_out[0], 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_clk", clk_out, 0);
    check("async_rst_strobe", strobe, 0);
    check("async_rst_pending", load_pending, 0);
    @(negedge Mclk) rst = 1'b0;
    model_reset();
    step();
    check("post_rst_default_div", {clk_out, strobe}, 10'h3FF);
    steps(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
